msg_tx_sched: RTL and testbench
===============================

// Module: msg_tx_sched
// PURPOSE
//  Round-robin scheduler sharing the single UART transmitter between NUM_REQ on-board message sources
//  (fault reports, block pick/drop reports, position reports).
//  - Grants one requester at a time.
//  - Serialises its fixed 7-byte frame "<H0><H1><H2>-<arg>-#" byte-by-byte over the tx_start/tx_done handshake.
//  - Acknowledges the requester when the frame is done.
//  Sits between the bot control FSMs and the uart_tx byte transmitter, mirror of the receive-side message parser.
// PARAMETERS
//  NUM_REQ      4      number of requesters (2..8)
//  TIMEOUT_CYC  50000  max clk_50M cycles to wait for tx_done per byte (used only with MSG_TX_TIMEOUT_EN)
// PORTS
//  clk_50M      in   1          system clock, 50 MHz, all logic on rising edge
//  rst_n        in   1          asynchronous active-low reset
//  req_valid    in   NUM_REQ    per-requester send request, level; held until req_ack
//  req_arg      in   NUM_REQ*8  per-requester ASCII argument byte, requester i at [8*i+7:8*i]
//  req_ack      out  NUM_REQ    one-cycle pulse: frame of requester i fully transmitted
//  busy         out  1          high from grant until the cycle req_ack pulses
//  grant_id     out  clog2(NUM_REQ)  index of current/last granted requester
//  tx_data      out  8          byte to transmit, stable from tx_start until tx_done
//  tx_start     out  1          one-cycle pulse: uart_tx to latch tx_data
//  tx_done      in   1          one-cycle pulse from uart_tx: byte finished
//  timeout_err  out  1          sticky: a byte timed out (tied 0 without MSG_TX_TIMEOUT_EN)
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - outputs req_ack, busy, grant_id, tx_data, tx_start, timeout_err all = 0
//   - state=IDLE, rr_ptr=0, byte_idx=0, timeout counter=0
//   - Reset mid-frame abandons the frame; no ack is issued.
//  States IDLE -> SEND -> WAIT -> (SEND | ACK) -> IDLE:
//   - IDLE: if any req_valid, pick the first set bit searching rr_ptr, rr_ptr+1, ... mod NUM_REQ.
//     Latch grant_id and snapshot that requester's req_arg; byte_idx=0; busy=1; go SEND.
//     Later changes of req_arg or req_valid do not affect the frame; a dropped req_valid does not abort it.
//   - SEND: register tx_data=frame[byte_idx], tx_start=1 (high exactly one cycle); go WAIT.
//   - WAIT: on tx_done, if byte_idx==6 go ACK, else byte_idx+1 and go SEND.
//   - ACK: req_ack[grant_id]=1 for one cycle; busy=0; rr_ptr=(grant_id+1) mod NUM_REQ; go IDLE.
//  tx_done is honoured only in WAIT; in IDLE/SEND/ACK it is ignored (no state change).
//  Frame bytes, index 0..6: HDR[g][0], HDR[g][1], HDR[g][2], 8'h2D, arg', 8'h2D, 8'h23.
//   - arg' = 8'h3F if the snapshot arg is 8'h23 ('#' would terminate the frame early at the receiver).
//   - Otherwise arg' = arg.
//  Timing:
//   - tx_start of byte 0 rises 2 edges after the edge sampling req_valid.
//   - Each later tx_start rises 2 edges after the edge sampling tx_done.
//   - req_ack pulses 1 edge after the edge sampling the final tx_done.
//  A requester still holding req_valid in the cycle after its ack is treated as a new request.
//   - It is lowest priority next round because of rr_ptr.
//  Simultaneous requests: granted in rotation, no requester starves (max wait NUM_REQ-1 frames).
// CONFIGURATION
//  MSG_TX_TIMEOUT_EN defined:
//   - A 16+ bit counter clears on entry to WAIT and increments each WAIT cycle.
//   - If it reaches TIMEOUT_CYC without tx_done, set timeout_err (sticky until reset), skip the remaining bytes,
//     and go to ACK, so the requester is released with a normal req_ack pulse.
//  MSG_TX_TIMEOUT_EN not defined:
//   - WAIT waits forever for tx_done; no counter is built; timeout_err is constant 0.
// STRUCTURE
//  Package msg_pkg:
//   - ASCII constants DASH=8'h2D, HASH=8'h23, QMARK=8'h3F; MSG_LEN=7
//   - header table HDR[0..3] = "FIM","BPM","BDM","POS"
//   - state encoding IDLE/SEND/WAIT/ACK
//  Sub-module rr_arbiter:
//   - combinational; inputs req_valid, rr_ptr; outputs any_req, winner index
//   - instantiated once
//  Frame byte mux and FSM stay in msg_tx_sched.
// TESTING
//  1. Only req_valid[1], arg 8'h45 -> tx bytes 42 50 4D 2D 45 2D 23, each after one tx_done; one req_ack[1] pulse; busy low after.
//  2. req_valid[0] and [2] together from reset, held until ack -> frame for 0 then frame for 2; second round with 0,2 again -> 0 then 2.
//     Assert req[2] during frame 0 and re-assert req[0] at its ack -> 2 served before 0.
//  3. arg 8'h23 on requester 3 -> bytes 50 4F 53 2D 3F 2D 23.
//  4. Change req_arg after grant, drop req_valid mid-frame, pulse tx_done in IDLE -> original arg sent, frame completes, stray tx_done ignored.
//  5. rst_n low during byte 3 -> all outputs 0 immediately; after release a new request restarts at byte 0 with rr_ptr=0.
//  6. With MSG_TX_TIMEOUT_EN, TIMEOUT_CYC=100, withhold tx_done at byte 2 -> after 100 WAIT cycles timeout_err=1, req_ack pulse.
//     Without the macro -> stays in WAIT, busy=1.

Source files
------------

// File: rtl/msg_pkg.sv
// Shared constants for the UART message transmit scheduler: ASCII framing bytes,
// per-source frame headers, FSM state encoding and the frame byte lookup.
package msg_pkg;

   localparam logic [7:0] DASH  = 8'h2D;
   localparam logic [7:0] HASH  = 8'h23;
   localparam logic [7:0] QMARK = 8'h3F;
   localparam int         MSG_LEN = 7;

   // HDR[0]="FIM", HDR[1]="BPM", HDR[2]="BDM", HDR[3]="POS"; first character in [23:16]
   localparam logic [3:0][23:0] HDR = {"POS", "BDM", "BPM", "FIM"};

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      WAIT = 2'd2,
      ACK  = 2'd3
   } state_t;

   // A literal '#' argument would end the frame early at the receiver, so it is sent as '?'
   function automatic logic [7:0] frame_byte(input logic [1:0] hdr_sel,
                                             input logic [2:0] idx,
                                             input logic [7:0] arg);
      logic [7:0] b;
      case (idx)
         3'd0:    b = HDR[hdr_sel][23:16];
         3'd1:    b = HDR[hdr_sel][15:8];
         3'd2:    b = HDR[hdr_sel][7:0];
         3'd3:    b = DASH;
         3'd4:    b = (arg == HASH) ? QMARK : arg;
         3'd5:    b = DASH;
         default: b = HASH;
      endcase
      return b;
   endfunction

endpackage

// File: rtl/msg_tx_sched_rr_arbiter.sv
// Combinational round-robin pick: first asserted request searching from rr_ptr upward,
// wrapping modulo NUM_REQ.
module rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int IDW     = 2
) (
   input  logic [NUM_REQ-1:0] req_valid,
   input  logic [IDW-1:0]     rr_ptr,
   output logic               any_req,
   output logic [IDW-1:0]     winner
);

   logic found;

   always_comb begin
      any_req = |req_valid;
      winner  = '0;
      found   = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         int j;
         j = int'(rr_ptr) + i;
         if (j >= NUM_REQ) j = j - NUM_REQ;
         if (!found && req_valid[j]) begin
            winner = IDW'(j);
            found  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/msg_tx_sched.sv
// Round-robin scheduler sharing one UART byte transmitter between NUM_REQ message sources.
// Optional per-byte tx_done watchdog is built only when MSG_TX_TIMEOUT_EN is defined.
//
// state | meaning
// IDLE  | no frame in flight, arbitrating on req_valid
// SEND  | present frame[byte_idx] and pulse tx_start
// WAIT  | waiting for tx_done of the current byte
// ACK   | one-cycle req_ack to the granted source, advance rr_ptr
module msg_tx_sched
   import msg_pkg::*;
#(
   parameter  int NUM_REQ     = 4,
   parameter  int TIMEOUT_CYC = 50000,
   localparam int IDW         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                 clk_50M,
   input  logic                 rst_n,
   input  logic [NUM_REQ-1:0]   req_valid,
   input  logic [NUM_REQ*8-1:0] req_arg,
   output logic [NUM_REQ-1:0]   req_ack,
   output logic                 busy,
   output logic [IDW-1:0]       grant_id,
   output logic [7:0]           tx_data,
   output logic                 tx_start,
   input  logic                 tx_done,
   output logic                 timeout_err
);

   if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
      $error("msg_tx_sched: NUM_REQ must be 2..8");
   end
   if (TIMEOUT_CYC < 1) begin : g_bad_timeout
      $error("msg_tx_sched: TIMEOUT_CYC must be positive");
   end

   state_t         state_q, state_d;
   logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
   logic [IDW-1:0] grant_id_q, grant_id_d;
   logic [2:0]     byte_idx_q, byte_idx_d;
   logic [7:0]     arg_q, arg_d;
   logic [7:0]     tx_data_q, tx_data_d;
   logic           tx_start_q, tx_start_d;
   logic           busy_q, busy_d;
   logic           any_req;
   logic [IDW-1:0] winner;
   logic [1:0]     hdr_sel;

`ifdef MSG_TX_TIMEOUT_EN
   localparam int TMO_W = ($clog2(TIMEOUT_CYC + 1) > 16) ? $clog2(TIMEOUT_CYC + 1) : 16;
   logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
   logic             timeout_err_q, timeout_err_d;
   assign timeout_err = timeout_err_q;
`else
   assign timeout_err = 1'b0;
`endif

   rr_arbiter #(.NUM_REQ(NUM_REQ), .IDW(IDW)) u_arb (
      .req_valid (req_valid),
      .rr_ptr    (rr_ptr_q),
      .any_req   (any_req),
      .winner    (winner)
   );

   // Sources beyond the four defined headers reuse the table cyclically
   assign hdr_sel = 2'(int'(grant_id_q) % 4);

   always_comb begin
      state_d    = state_q;
      rr_ptr_d   = rr_ptr_q;
      grant_id_d = grant_id_q;
      byte_idx_d = byte_idx_q;
      arg_d      = arg_q;
      tx_data_d  = tx_data_q;
      tx_start_d = 1'b0;
      busy_d     = busy_q;
      req_ack    = '0;
`ifdef MSG_TX_TIMEOUT_EN
      tmo_cnt_d     = tmo_cnt_q;
      timeout_err_d = timeout_err_q;
`endif
      case (state_q)
         IDLE: begin
            if (any_req) begin
               grant_id_d = winner;
               arg_d      = req_arg[8*int'(winner) +: 8];
               byte_idx_d = '0;
               busy_d     = 1'b1;
               state_d    = SEND;
            end
         end
         SEND: begin
            tx_data_d  = frame_byte(hdr_sel, byte_idx_q, arg_q);
            tx_start_d = 1'b1;
            state_d    = WAIT;
`ifdef MSG_TX_TIMEOUT_EN
            tmo_cnt_d  = '0;
`endif
         end
         WAIT: begin
            if (tx_done) begin
               if (byte_idx_q == 3'(MSG_LEN - 1)) begin
                  busy_d  = 1'b0;
                  state_d = ACK;
               end else begin
                  byte_idx_d = byte_idx_q + 3'd1;
                  state_d    = SEND;
               end
            end
`ifdef MSG_TX_TIMEOUT_EN
            // Abandon the rest of the frame but still release the source with an ack
            else if (tmo_cnt_q == TMO_W'(TIMEOUT_CYC - 1)) begin
               timeout_err_d = 1'b1;
               busy_d        = 1'b0;
               state_d       = ACK;
            end else begin
               tmo_cnt_d = tmo_cnt_q + 1'b1;
            end
`endif
         end
         ACK: begin
            req_ack  = NUM_REQ'(1) << grant_id_q;
            rr_ptr_d = (grant_id_q == IDW'(NUM_REQ - 1)) ? '0 : grant_id_q + 1'b1;
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_50M or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         rr_ptr_q      <= '0;
         grant_id_q    <= '0;
         byte_idx_q    <= '0;
         arg_q         <= '0;
         tx_data_q     <= '0;
         tx_start_q    <= 1'b0;
         busy_q        <= 1'b0;
`ifdef MSG_TX_TIMEOUT_EN
         tmo_cnt_q     <= '0;
         timeout_err_q <= 1'b0;
`endif
      end else begin
         state_q       <= state_d;
         rr_ptr_q      <= rr_ptr_d;
         grant_id_q    <= grant_id_d;
         byte_idx_q    <= byte_idx_d;
         arg_q         <= arg_d;
         tx_data_q     <= tx_data_d;
         tx_start_q    <= tx_start_d;
         busy_q        <= busy_d;
`ifdef MSG_TX_TIMEOUT_EN
         tmo_cnt_q     <= tmo_cnt_d;
         timeout_err_q <= timeout_err_d;
`endif
      end
   end

   assign busy     = busy_q;
   assign grant_id = grant_id_q;
   assign tx_data  = tx_data_q;
   assign tx_start = tx_start_q;

endmodule

// File: tb/tb_msg_tx_sched.sv
// Self-checking bench for msg_tx_sched: directed steps plus randomized request traffic
// checked against a frame-level round-robin model.
module tb_msg_tx_sched;

   logic        clk_50M = 1'b0;
   logic        rst_n;
   logic [3:0]  req_valid;
   logic [31:0] req_arg;
   logic [3:0]  req_ack;
   logic        busy;
   logic [1:0]  grant_id;
   logic [7:0]  tx_data;
   logic        tx_start;
   logic        tx_done;
   logic        timeout_err;

   int         checks = 0;
   int         errors = 0;
   logic [3:0] pend;
   logic [7:0] args [4];
   int         rr;
   string      hdrs [4] = '{"FIM", "BPM", "BDM", "POS"};

   msg_tx_sched #(.NUM_REQ(4), .TIMEOUT_CYC(100)) dut (
      .clk_50M     (clk_50M),
      .rst_n       (rst_n),
      .req_valid   (req_valid),
      .req_arg     (req_arg),
      .req_ack     (req_ack),
      .busy        (busy),
      .grant_id    (grant_id),
      .tx_data     (tx_data),
      .tx_start    (tx_start),
      .tx_done     (tx_done),
      .timeout_err (timeout_err)
   );

   always #10 clk_50M = ~clk_50M;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_50M);
      #1;
   endtask

   function automatic logic [7:0] exp_byte(input int g, input int k, input logic [7:0] a);
      string h;
      h = hdrs[g];
      case (k)
         0, 1, 2: return h[k];
         3, 5:    return 8'h2D;
         4:       return (a == 8'h23) ? 8'h3F : a;
         default: return 8'h23;
      endcase
   endfunction

   function automatic int predict();
      for (int i = 0; i < 4; i++) begin
         int j;
         j = (rr + i) % 4;
         if (pend[j]) return j;
      end
      return -1;
   endfunction

   function automatic logic [7:0] rand_arg();
      if ($urandom_range(0, 3) == 0) return 8'h23;
      return 8'($urandom_range(32, 126));
   endfunction

   task automatic set_req(input int j, input logic [7:0] a);
      req_valid[j]       = 1'b1;
      req_arg[8*j +: 8]  = a;
      args[j]            = a;
      pend[j]            = 1'b1;
   endtask

   task automatic send_byte(input int g, input int k, input logic [7:0] a);
      int n;
      n = 0;
      while (tx_start !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      check($sformatf("tx_start_seen g%0d b%0d", g, k), 32'(tx_start), 1);
      check($sformatf("tx_data g%0d b%0d", g, k), 32'(tx_data), 32'(exp_byte(g, k, a)));
      check("grant_id", 32'(grant_id), 32'(g));
      check("busy_in_frame", 32'(busy), 1);
   endtask

   task automatic pulse_done();
      repeat ($urandom_range(0, 3)) tick();
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
   endtask

   task automatic serve_frame(input int g, input logic [7:0] a, input logic [3:0] add_mask,
                              input bit keep, input bit disturb);
      for (int k = 0; k < 7; k++) begin
         send_byte(g, k, a);
         if (disturb && k == 2) begin
            req_arg[8*g +: 8] = ~a;
            req_valid[g]      = 1'b0;
            pend[g]           = 1'b0;
         end
         if (k == 3) begin
            for (int j = 0; j < 4; j++)
               if (add_mask[j] && !pend[j] && j != g) set_req(j, rand_arg());
         end
         pulse_done();
         if (k < 6) check("ack_early", 32'(req_ack), 0);
      end
      check($sformatf("req_ack g%0d", g), 32'(req_ack), 32'(1 << g));
      check("busy_at_ack", 32'(busy), 0);
      if (!keep) begin
         req_valid[g] = 1'b0;
         pend[g]      = 1'b0;
      end
      rr = (g + 1) % 4;
   endtask

   task automatic serve_next(input logic [3:0] add_mask, input bit keep, input bit disturb);
      int g;
      g = predict();
      if (g >= 0) serve_frame(g, args[g], add_mask, keep, disturb);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_req_ack"},     32'(req_ack), 0);
      check({tag, "_busy"},        32'(busy), 0);
      check({tag, "_grant_id"},    32'(grant_id), 0);
      check({tag, "_tx_data"},     32'(tx_data), 0);
      check({tag, "_tx_start"},    32'(tx_start), 0);
      check({tag, "_timeout_err"}, 32'(timeout_err), 0);
   endtask

   initial begin
      int n;
      rst_n     = 1'b0;
      req_valid = '0;
      req_arg   = '0;
      tx_done   = 1'b0;
      pend      = '0;
      rr        = 0;
      foreach (args[i]) args[i] = 8'h00;

      repeat (3) @(posedge clk_50M);
      #1;
      check_all_zero("reset");
      rst_n = 1'b1;
      tick();

      // single requester, exact first-byte latency
      set_req(1, 8'h45);
      tick();
      check("t1_busy_at_grant", 32'(busy), 1);
      check("t1_no_start_yet", 32'(tx_start), 0);
      tick();
      check("t1_start_latency", 32'(tx_start), 1);
      serve_frame(1, 8'h45, 4'b0000, 1'b0, 1'b0);
      tick();
      check("t1_busy_after", 32'(busy), 0);

      // two simultaneous requesters, mid-frame arrival and held request at ack
      set_req(0, 8'h31);
      set_req(2, 8'h32);
      serve_next(4'b0000, 1'b0, 1'b0);
      serve_next(4'b0100, 1'b1, 1'b0);
      while (pend != 0) serve_next(4'b0000, 1'b0, 1'b0);

      for (int r = 0; r < 24; r++) begin
         logic [3:0] m;
         bit d, kp;
         m = 4'($urandom_range(0, 15));
         if (pend == 0 && m == 0) m = 4'(1 << $urandom_range(0, 3));
         for (int j = 0; j < 4; j++)
            if (m[j] && !pend[j]) set_req(j, rand_arg());
         d  = ($urandom_range(0, 4) == 0);
         kp = !d && ($urandom_range(0, 2) == 0);
         serve_next(4'($urandom_range(0, 15)), kp, d);
      end
      while (pend != 0) serve_next(4'b0000, 1'b0, 1'b0);

      // stray tx_done while idle, then a '#' argument
      repeat (3) tick();
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
      tick();
      check("stray_busy", 32'(busy), 0);
      check("stray_start", 32'(tx_start), 0);
      check("stray_ack", 32'(req_ack), 0);
      set_req(3, 8'h23);
      serve_next(4'b0000, 1'b0, 1'b0);

      // reset in the middle of a frame
      set_req(1, rand_arg());
      serve_next(4'b0000, 1'b0, 1'b0);
      set_req(2, 8'h41);
      for (int k = 0; k < 3; k++) begin
         send_byte(2, k, 8'h41);
         pulse_done();
      end
      send_byte(2, 3, 8'h41);
      rst_n = 1'b0;
      #1;
      check_all_zero("midrst");
      req_valid = '0;
      pend      = '0;
      rr        = 0;
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      set_req(1, rand_arg());
      set_req(3, rand_arg());
      serve_next(4'b0000, 1'b0, 1'b0);
      serve_next(4'b0000, 1'b0, 1'b0);

      // withheld tx_done on byte 2
      set_req(0, 8'h30);
      for (int k = 0; k < 2; k++) begin
         send_byte(0, k, 8'h30);
         pulse_done();
      end
      send_byte(0, 2, 8'h30);
`ifdef MSG_TX_TIMEOUT_EN
      n = 0;
      while (req_ack !== 4'b0001 && n < 300) begin
         tick();
         n++;
      end
      check("tmo_wait_cycles", 32'(n), 100);
      check("tmo_err", 32'(timeout_err), 1);
      check("tmo_busy", 32'(busy), 0);
      req_valid = '0;
      pend      = '0;
      rr        = 1;
      tick();
      tick();
      check("tmo_sticky", 32'(timeout_err), 1);
`else
      n = 0;
      repeat (200) begin
         tick();
         n++;
      end
      check("notmo_busy", 32'(busy), 1);
      check("notmo_ack", 32'(req_ack), 0);
      check("notmo_err", 32'(timeout_err), 0);
      check("notmo_start", 32'(tx_start), 0);
      rst_n     = 1'b0;
      req_valid = '0;
      pend      = '0;
      rr        = 0;
      tick();
      rst_n = 1'b1;
      tick();
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
